ref_window_mem: RTL and testbench

Parametrised reference-window memory for the integer motion-estimation array: BANKS independent pixel banks with per-bank write addressing, a multi-row burst read that assembles RD_ROWS consecutive rows into one wide word for the PE array, and a single-row read mode for incremental window refresh. It sits between the reference-frame loader (write side) and the SAD/PE array (read side), and supersedes the fixed 32-bank / 8-row reference memory with configurable geometry, a read handshake, and optional write-to-read bypass.

---
 rtl/ref_window_mem_if.sv | 42 ++++
 rtl/ref_window_mem.sv | 167 ++++++++++++++++
 tb/tb_ref_window_mem.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ref_window_mem_if.sv
// ref_window_mem_if: write-side and read-side bus of the reference-window
// memory. The loader and PE array use the master modport; the memory uses
// the slave modport. clk and rst are not part of the bundle.
interface ref_window_mem_if #(
   parameter int PIXEL   = 8,
   parameter int BANKS   = 32,
   parameter int DEPTH   = 128,
   parameter int RD_ROWS = 8
);
   localparam int AW  = $clog2(DEPTH);
   localparam int RSW = $clog2(RD_ROWS);

   // write side
   logic                        wr_en;
   logic [BANKS-1:0]            bank_sel;
   logic [BANKS*PIXEL-1:0]      wr_data;
   logic [BANKS*AW-1:0]         wr_addr_all;

   // read request
   logic                        rd_req;
   logic                        rd_mode;
   logic [AW-1:0]               rd_addr;
   logic [RSW-1:0]              rd_row_sel;

   // read response
   logic                        rd_busy;
   logic [RD_ROWS*BANKS*PIXEL-1:0] rd_data;
   logic                        rd_multi_valid;
   logic                        rd_single_valid;

   modport master (
      output wr_en, bank_sel, wr_data, wr_addr_all,
      output rd_req, rd_mode, rd_addr, rd_row_sel,
      input  rd_busy, rd_data, rd_multi_valid, rd_single_valid
   );

   modport slave (
      input  wr_en, bank_sel, wr_data, wr_addr_all,
      input  rd_req, rd_mode, rd_addr, rd_row_sel,
      output rd_busy, rd_data, rd_multi_valid, rd_single_valid
   );
endinterface

// File: rtl/ref_window_mem.sv
// ref_window_mem: BANKS independent pixel banks (DEPTH rows each) with
// per-bank write addressing, an RD_ROWS-row burst read into a wide output
// word, and a single-row read into one selected slot.
// Optional feature macro: REF_MEM_WR_BYPASS_EN -- when defined, a read that
// coincides with a write to the same bank and row captures the new pixel;
// otherwise the old stored pixel is captured (read-before-write).
module ref_window_mem #(
   parameter int PIXEL   = 8,
   parameter int BANKS   = 32,
   parameter int DEPTH   = 128,
   parameter int RD_ROWS = 8
) (
   input  logic            clk,
   input  logic            rst,
   ref_window_mem_if.slave bus
);
   localparam int AW    = $clog2(DEPTH);
   localparam int RSW   = $clog2(RD_ROWS);
   localparam int ROW_W = BANKS * PIXEL;

   // geometry sanity checks at elaboration
   if ((1 << AW) != DEPTH) begin : g_chk_depth
      $error("ref_window_mem: DEPTH must be a power of two");
   end
   if ((1 << RSW) != RD_ROWS || RD_ROWS < 2 || RD_ROWS > DEPTH) begin : g_chk_rows
      $error("ref_window_mem: RD_ROWS must be a power of two in [2, DEPTH]");
   end

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      SINGLE
   } state_t;

   state_t                 state_q, state_d;
   logic [AW-1:0]          base_q, base_d;
   logic [RSW-1:0]         cnt_q, cnt_d;
   logic [RSW-1:0]         sel_q, sel_d;
   logic                   multi_valid_q, multi_valid_d;
   logic                   single_valid_q, single_valid_d;

   logic                   capture_en;
   logic [RSW-1:0]         capture_slot;
   logic [AW-1:0]          rd_row;
   logic [ROW_W-1:0]       row_word;
   logic [RD_ROWS-1:0][ROW_W-1:0] slot_q;

   // ------------------------------------------------------------------
   // Pixel banks: one write port and one read port each. All banks share
   // the read row; each bank has its own write address.
   // ------------------------------------------------------------------
   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic [PIXEL-1:0] mem [DEPTH];
      logic             we;
      logic [AW-1:0]    wa;
      logic [PIXEL-1:0] wd;
      logic [PIXEL-1:0] rd_pix;

      assign we = bus.wr_en & bus.bank_sel[b];
      assign wa = bus.wr_addr_all[b*AW +: AW];
      assign wd = bus.wr_data[b*PIXEL +: PIXEL];

      // storage write; contents deliberately left unreset
      always_ff @(posedge clk) begin
         if (we) begin
            mem[wa] <= wd;
         end
      end

`ifdef REF_MEM_WR_BYPASS_EN
      // a write landing on the row being read this cycle is forwarded
      assign rd_pix = (we && (wa == rd_row)) ? wd : mem[rd_row];
`else
      // capture and write share the edge, so the old pixel is seen
      assign rd_pix = mem[rd_row];
`endif

      assign row_word[b*PIXEL +: PIXEL] = rd_pix;
   end

   // ------------------------------------------------------------------
   // Read engine
   // ------------------------------------------------------------------

   // read FSM state and request context registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         base_q         <= '0;
         cnt_q          <= '0;
         sel_q          <= '0;
         multi_valid_q  <= 1'b0;
         single_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         base_q         <= base_d;
         cnt_q          <= cnt_d;
         sel_q          <= sel_d;
         multi_valid_q  <= multi_valid_d;
         single_valid_q <= single_valid_d;
      end
   end

   // next-state, read row and capture control
   always_comb begin
      state_d        = state_q;
      base_d         = base_q;
      cnt_d          = cnt_q;
      sel_d          = sel_q;
      multi_valid_d  = 1'b0;
      single_valid_d = 1'b0;
      capture_en     = 1'b0;
      capture_slot   = cnt_q;
      rd_row         = base_q;

      unique case (state_q)
         IDLE: begin
            if (bus.rd_req) begin
               base_d  = bus.rd_addr;
               sel_d   = bus.rd_row_sel;
               cnt_d   = '0;
               state_d = bus.rd_mode ? SINGLE : BURST;
            end
         end

         BURST: begin
            // AW-bit add wraps modulo DEPTH
            rd_row       = base_q + AW'(cnt_q);
            capture_en   = 1'b1;
            capture_slot = cnt_q;
            cnt_d        = cnt_q + RSW'(1);
            if (cnt_q == RSW'(RD_ROWS - 1)) begin
               cnt_d         = '0;
               state_d       = IDLE;
               multi_valid_d = 1'b1;
            end
         end

         SINGLE: begin
            rd_row         = base_q;
            capture_en     = 1'b1;
            capture_slot   = sel_q;
            state_d        = IDLE;
            single_valid_d = 1'b1;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // output slots: cleared on reset, one slot loaded per capture cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q <= '0;
      end else if (capture_en) begin
         slot_q[capture_slot] <= row_word;
      end
   end

   assign bus.rd_busy         = (state_q != IDLE);
   assign bus.rd_data         = slot_q;
   assign bus.rd_multi_valid  = multi_valid_q;
   assign bus.rd_single_valid = single_valid_q;

endmodule

// File: tb/tb_ref_window_mem.sv
// tb_ref_window_mem: table-driven and randomized checks of ref_window_mem
// against a row/slot array model of the reference window.
module tb_ref_window_mem;
   localparam int PIXEL   = 8;
   localparam int BANKS   = 32;
   localparam int DEPTH   = 128;
   localparam int RD_ROWS = 8;
   localparam int AW      = 7;
   localparam int RSW     = 3;
   localparam int ROW_W   = BANKS * PIXEL;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ref_window_mem_if #(.PIXEL(PIXEL), .BANKS(BANKS), .DEPTH(DEPTH), .RD_ROWS(RD_ROWS)) bus ();

   ref_window_mem #(.PIXEL(PIXEL), .BANKS(BANKS), .DEPTH(DEPTH), .RD_ROWS(RD_ROWS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int unsigned tests = 0;
   int unsigned fails = 0;

   byte unsigned model_mem  [BANKS][DEPTH];
   byte unsigned model_slot [RD_ROWS][BANKS];

   typedef struct {
      logic mode;
      int   addr;
      int   sel;
      int   lat;
      int   chk_slot;
      int   chk_byte;
   } vec_t;

   vec_t tbl [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input longint got, input longint want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   function automatic byte unsigned dut_pix(input int k, input int b);
      return bus.rd_data[(k*BANKS+b)*PIXEL +: PIXEL];
   endfunction

   function automatic logic [ROW_W-1:0] exp_row(input int k);
      logic [ROW_W-1:0] r;
      for (int b = 0; b < BANKS; b++) r[b*PIXEL +: PIXEL] = model_slot[k][b];
      return r;
   endfunction

   task automatic cmp_data(input string name);
      int bad = -1;
      for (int k = 0; k < RD_ROWS; k++)
         for (int b = 0; b < BANKS; b++)
            if (bad < 0 && dut_pix(k, b) != model_slot[k][b]) bad = k;
      tests++;
      if (bad >= 0) begin
         fails++;
         $display("FAIL %s: slot %0d got %h want %h", name, bad,
                  bus.rd_data[bad*ROW_W +: ROW_W], exp_row(bad));
      end
   endtask

   task automatic chk_slot_banks(input string name, input int k, input int lo, input int hi,
                                 input int want);
      int bad = -1;
      for (int b = lo; b <= hi; b++)
         if (bad < 0 && dut_pix(k, b) != byte'(want)) bad = b;
      tests++;
      if (bad >= 0) begin
         fails++;
         $display("FAIL %s: slot %0d bank %0d got %h want %h", name, k, bad,
                  dut_pix(k, bad), byte'(want));
      end
   endtask

   // expected slot contents from the row rules: burst = consecutive rows mod DEPTH
   task automatic model_burst(input int addr);
      for (int k = 0; k < RD_ROWS; k++)
         for (int b = 0; b < BANKS; b++)
            model_slot[k][b] = model_mem[b][(addr + k) % DEPTH];
   endtask

   task automatic model_single(input int addr, input int sel);
      for (int b = 0; b < BANKS; b++) model_slot[sel][b] = model_mem[b][addr];
   endtask

   task automatic do_write(input logic [BANKS-1:0] sel, input logic [BANKS*PIXEL-1:0] data,
                           input logic [BANKS*AW-1:0] addr);
      bus.wr_en       = 1'b1;
      bus.bank_sel    = sel;
      bus.wr_data     = data;
      bus.wr_addr_all = addr;
      for (int b = 0; b < BANKS; b++)
         if (sel[b]) model_mem[b][int'(addr[b*AW +: AW])] = data[b*PIXEL +: PIXEL];
      tick();
      bus.wr_en = 1'b0;
   endtask

   // one complete read transaction with handshake and timing checks
   task automatic do_read(input string tag, input logic mode, input int addr, input int sel,
                          input int exp_lat);
      int lat   = 0;
      bit busy_ok = 1'b1;
      bit other = 1'b0;
      chk({tag, "_idle_before"}, bus.rd_busy, 0);
      bus.rd_req     = 1'b1;
      bus.rd_mode    = mode;
      bus.rd_addr    = AW'(addr);
      bus.rd_row_sel = RSW'(sel);
      tick();
      bus.rd_req     = 1'b0;
      // request fields must not matter after acceptance
      bus.rd_mode    = 1'($urandom);
      bus.rd_addr    = AW'($urandom);
      bus.rd_row_sel = RSW'($urandom);
      for (int i = 1; i <= 20; i++) begin
         if (!bus.rd_busy) busy_ok = 1'b0;
         tick();
         if (mode ? bus.rd_multi_valid : bus.rd_single_valid) other = 1'b1;
         if (mode ? bus.rd_single_valid : bus.rd_multi_valid) begin
            lat = i;
            break;
         end
      end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_busy_held"}, busy_ok, 1);
      chk({tag, "_wrong_valid"}, other, 0);
      chk({tag, "_busy_at_valid"}, bus.rd_busy, 0);
      if (mode) model_single(addr, sel);
      else      model_burst(addr);
      cmp_data({tag, "_data"});
      tick();
      chk({tag, "_valid_one_cycle"}, bus.rd_multi_valid | bus.rd_single_valid, 0);
   endtask

   initial begin
      logic [BANKS*PIXEL-1:0] wd;
      logic [BANKS*AW-1:0]    wa;
      logic [PIXEL-1:0]       pix;
      int nm, ns, lat, exp0;

      tbl[0] = '{1'b0,   0, 0, RD_ROWS, 0, 8'h01};
      tbl[1] = '{1'b0, 126, 0, RD_ROWS, 1, 8'h80};
      tbl[2] = '{1'b1,  10, 3, 1,       3, 8'h0B};
      tbl[3] = '{1'b0, 120, 0, RD_ROWS, 7, 8'h80};
      tbl[4] = '{1'b1, 127, 5, 1,       5, 8'h80};
      tbl[5] = '{1'b0,  64, 0, RD_ROWS, 3, 8'h44};
      tbl[6] = '{1'b1,   0, 0, 1,       0, 8'h01};
      tbl[7] = '{1'b0, 126, 0, RD_ROWS, 2, 8'h01};

      rst             = 1'b1;
      bus.wr_en       = 1'b0;
      bus.bank_sel    = '0;
      bus.wr_data     = '0;
      bus.wr_addr_all = '0;
      bus.rd_req      = 1'b0;
      bus.rd_mode     = 1'b0;
      bus.rd_addr     = '0;
      bus.rd_row_sel  = '0;
      for (int k = 0; k < RD_ROWS; k++)
         for (int b = 0; b < BANKS; b++) model_slot[k][b] = 8'h00;

      // reset state
      tick();
      tick();
      chk("reset_busy", bus.rd_busy, 0);
      chk("reset_multi_valid", bus.rd_multi_valid, 0);
      chk("reset_single_valid", bus.rd_single_valid, 0);
      chk("reset_data_zero", bus.rd_data == '0, 1);
      rst = 1'b0;
      tick();
      chk("post_reset_busy", bus.rd_busy, 0);

      // fill: row r of every bank = r+1
      for (int r = 0; r < DEPTH; r++) begin
         pix = PIXEL'(r + 1);
         wd  = {BANKS{pix}};
         wa  = {BANKS{AW'(r)}};
         do_write('1, wd, wa);
      end

      // table of reads against the filled window
      for (int i = 0; i < 8; i++) begin
         do_read($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].addr, tbl[i].sel, tbl[i].lat);
         chk_slot_banks($sformatf("tbl%0d_byte", i), tbl[i].chk_slot, 0, BANKS-1, tbl[i].chk_byte);
      end

      // partial bank write, then a burst with a dropped request mid-burst
      do_write(32'h0000_000F, {BANKS{8'hAA}}, {BANKS{7'd2}});
      bus.rd_req = 1'b1; bus.rd_mode = 1'b0; bus.rd_addr = '0;
      tick();
      nm = 0; ns = 0; lat = 0;
      for (int i = 1; i <= 12; i++) begin
         if (i == 3) begin
            bus.rd_req = 1'b1; bus.rd_mode = 1'b1; bus.rd_addr = 7'd50; bus.rd_row_sel = 3'd6;
         end else begin
            bus.rd_req = 1'b0;
         end
         tick();
         if (bus.rd_multi_valid) begin nm++; lat = i; end
         if (bus.rd_single_valid) ns++;
      end
      bus.rd_req = 1'b0;
      chk("partial_multi_pulses", nm, 1);
      chk("partial_single_pulses", ns, 0);
      chk("partial_latency", lat, RD_ROWS);
      chk("partial_idle_after", bus.rd_busy, 0);
      model_burst(0);
      chk_slot_banks("partial_slot2_lo", 2, 0, 3, 8'hAA);
      chk_slot_banks("partial_slot2_hi", 2, 4, BANKS-1, 8'h03);
      cmp_data("partial_data");

      // collision: write row 0 in the capture cycle of slot 0
      bus.rd_req = 1'b1; bus.rd_mode = 1'b0; bus.rd_addr = '0;
      tick();
      bus.rd_req      = 1'b0;
      bus.wr_en       = 1'b1;
      bus.bank_sel    = '1;
      bus.wr_data     = {BANKS{8'h55}};
      bus.wr_addr_all = '0;
      tick();
      bus.wr_en = 1'b0;
`ifdef REF_MEM_WR_BYPASS_EN
      exp0 = 8'h55;
`else
      exp0 = 8'h01;
`endif
      model_burst(0);
      for (int b = 0; b < BANKS; b++) begin
         model_slot[0][b] = byte'(exp0);
         model_mem[b][0]  = 8'h55;
      end
      lat = 0;
      if (bus.rd_multi_valid) lat = 1;
      for (int i = 2; i <= 20 && lat == 0; i++) begin
         tick();
         if (bus.rd_multi_valid) lat = i;
      end
      chk("coll_latency", lat, RD_ROWS);
      chk_slot_banks("coll_slot0", 0, 0, BANKS-1, exp0);
      cmp_data("coll_data");
      tick();

      // reset in the middle of a burst
      bus.rd_req = 1'b1; bus.rd_mode = 1'b0; bus.rd_addr = 7'd16;
      tick();
      bus.rd_req = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      #1;
      chk("rst_mid_data_zero", bus.rd_data == '0, 1);
      chk("rst_mid_busy", bus.rd_busy, 0);
      for (int k = 0; k < RD_ROWS; k++)
         for (int b = 0; b < BANKS; b++) model_slot[k][b] = 8'h00;
      tick();
      tick();
      rst = 1'b0;
      nm = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.rd_multi_valid || bus.rd_single_valid) nm++;
      end
      chk("rst_mid_no_valid", nm, 0);
      cmp_data("rst_mid_data_held");
      do_read("post_rst_burst", 1'b0, 16, 0, RD_ROWS);

      // randomized writes and reads against the model
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            for (int b = 0; b < BANKS; b++) begin
               wd[b*PIXEL +: PIXEL] = PIXEL'($urandom);
               wa[b*AW +: AW]       = AW'($urandom);
            end
            do_write(BANKS'($urandom), wd, wa);
         end else if ($urandom_range(0, 1) == 0) begin
            do_read($sformatf("rnd%0d_burst", it), 1'b0, $urandom_range(0, DEPTH-1), 0, RD_ROWS);
         end else begin
            do_read($sformatf("rnd%0d_single", it), 1'b1, $urandom_range(0, DEPTH-1),
                    $urandom_range(0, RD_ROWS-1), 1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
